// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit sitting between program/data memory and the CPU
// control unit. Owns the program counter, drives the (read-only) memory
// address port, assembles one- or two-word instructions into ir_hi/ir_lo and
// presents them to the CPU over a fetch_valid / fetch_ack handshake.
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   fetch_req    in   CPU requests the next instruction
//   fetch_ack    in   CPU has consumed ir_hi/ir_lo (only honoured in DONE)
//   pc_load      in   load pc from pc_in (honoured in IDLE and DONE only)
//   pc_in        in   jump/branch target
//   mem_rdata    in   memory read data, combinational from mem_addr
//   mem_addr     out  memory address, always equal to pc
//   mem_we       out  memory write enable, constant 0
//   pc           out  current program counter
//   ir_hi        out  first instruction word
//   ir_lo        out  second instruction word, 0 for one-word instructions
//   fetch_valid  out  ir_hi/ir_lo hold a complete instruction (DONE)
//   busy         out  fetch in progress (FETCH1 or FETCH2)
//   fetch_err    out  sticky PC-wrap flag
//
// Build option
//   FETCH_WRAP_ERR_EN : when defined, fetch_err latches on any fetch increment
//                       that wraps pc from all-ones to 0; cleared only by
//                       rst_n. When undefined, fetch_err is tied low.
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int START_PC   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic                  fetch_ack,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ir_hi,
    output logic [DATA_WIDTH-1:0] ir_lo,
    output logic                  fetch_valid,
    output logic                  busy,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [DATA_WIDTH-1:0]   ir_hi_reg, ir_hi_next;
    logic [DATA_WIDTH-1:0]   ir_lo_reg, ir_lo_next;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [3:0]              opcode;
    logic                    is_long;

    // Natural-width add: all-ones + 1 wraps to 0.
    assign pc_inc = pc_reg + ADDR_WIDTH'(1);

    // Two-word instructions carry an immediate operand: opcode 0..4 with
    // low nibble 8. Everything else is a single word.
    assign opcode  = mem_rdata[DATA_WIDTH-1 -: 4];
    assign is_long = (opcode <= 4'h4) && (mem_rdata[3:0] == 4'h8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= ADDR_WIDTH'(START_PC);
            ir_hi_reg <= '0;
            ir_lo_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_hi_reg <= ir_hi_next;
            ir_lo_reg <= ir_lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_hi_next = ir_hi_reg;
        ir_lo_next = ir_lo_reg;
        case (state_reg)
            IDLE: begin
                // A simultaneous load and request: the new pc is in place
                // before FETCH1 drives it onto mem_addr.
                if (pc_load)
                    pc_next = pc_in;
                if (fetch_req)
                    state_next = FETCH1;
            end
            FETCH1: begin
                ir_hi_next = mem_rdata;
                ir_lo_next = '0;
                pc_next    = pc_inc;
                state_next = is_long ? FETCH2 : DONE;
            end
            FETCH2: begin
                ir_lo_next = mem_rdata;
                pc_next    = pc_inc;
                state_next = DONE;
            end
            DONE: begin
                if (pc_load)
                    pc_next = pc_in;
                if (fetch_ack)
                    state_next = fetch_req ? FETCH1 : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_WRAP_ERR_EN
    logic fetch_err_reg;
    logic wrap_hit;

    // Only fetch increments count; pc_load to 0 is not a wrap.
    assign wrap_hit = ((state_reg == FETCH1) || (state_reg == FETCH2)) &&
                      (pc_reg == {ADDR_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_err_reg <= 1'b0;
        else if (wrap_hit)
            fetch_err_reg <= 1'b1;
    end

    assign fetch_err = fetch_err_reg;
`else
    assign fetch_err = 1'b0;
`endif

    assign pc          = pc_reg;
    assign mem_addr    = pc_reg;
    assign mem_we      = 1'b0;
    assign ir_hi       = ir_hi_reg;
    assign ir_lo       = ir_lo_reg;
    assign fetch_valid = (state_reg == DONE);
    assign busy        = (state_reg == FETCH1) || (state_reg == FETCH2);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

`ifdef FETCH_WRAP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        fetch_ack = 1'b0;
    logic        pc_load = 1'b0;
    logic [5:0]  pc_in = '0;
    logic [15:0] mem_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [5:0]  pc;
    logic [15:0] ir_hi;
    logic [15:0] ir_lo;
    logic        fetch_valid;
    logic        busy;
    logic        fetch_err;

    logic [15:0] mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: where the model believes the PC is, and the sticky wrap.
    int model_pc = 8;
    bit exp_err  = 1'b0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    instr_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .pc         (pc),
        .ir_hi      (ir_hi),
        .ir_lo      (ir_lo),
        .fetch_valid(fetch_valid),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    // Reference model: what one fetch starting at address p should produce.
    function automatic void model_fetch(input int p, output logic [15:0] hi,
                                        output logic [15:0] lo, output int np,
                                        output bit wrap, output int lat);
        bit lng;
        hi   = mem[p];
        lng  = (hi[15:12] <= 4'h4) && (hi[3:0] == 4'h8);
        lo   = lng ? mem[(p + 1) % 64] : 16'h0000;
        np   = (p + (lng ? 2 : 1)) % 64;
        wrap = (p == 63) || (lng && (p + 1 == 63));
        lat  = lng ? 3 : 2;
    endfunction

    function automatic logic [15:0] rand_word(input bit make_long);
        logic [15:0] w;
        w = 16'($urandom);
        if (make_long) begin
            w[15:12] = 4'($urandom_range(0, 4));
            w[3:0]   = 4'h8;
        end else begin
            w[15:12] = 4'($urandom_range(5, 15));
        end
        return w;
    endfunction

    // Stimulus helpers (no checking). All enter and leave at a negedge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 8;
        exp_err  = 1'b0;
    endtask

    task automatic issue_fetch(input bit load, input logic [5:0] target);
        fetch_req = 1'b1;
        pc_load   = load;
        pc_in     = target;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
    endtask

    // Counts edges since (and including) the one that sampled the request.
    task automatic wait_valid(output int edges);
        edges = 1;
        while (!fetch_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic ack_to_idle();
        fetch_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (pc !== 6'd8) begin n_fail++; $display("FAIL reset_pc: got %0d want 8", pc); end
        n_checks++; if (mem_addr !== 6'd8) begin n_fail++; $display("FAIL reset_addr: got %0d want 8", mem_addr); end
        n_checks++; if (ir_hi !== 16'h0 || ir_lo !== 16'h0) begin n_fail++; $display("FAIL reset_ir: got %h/%h want 0/0", ir_hi, ir_lo); end
        n_checks++; if (fetch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: valid=%b busy=%b want 0 0", fetch_valid, busy); end
        n_checks++; if (mem_we !== 1'b0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_we_err: we=%b err=%b want 0 0", mem_we, fetch_err); end
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 8;
        exp_err  = 1'b0;
    endtask

    task automatic test_one_word();
        int e;
        mem[8] = 16'h5123;
        issue_fetch(1'b0, 6'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL one_busy: got %b want 1", busy); end
        wait_valid(e);
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL one_latency: got %0d want 2", e); end
        n_checks++; if (ir_hi !== 16'h5123 || ir_lo !== 16'h0) begin n_fail++; $display("FAIL one_ir: got %h/%h want 5123/0000", ir_hi, ir_lo); end
        n_checks++; if (pc !== 6'd9) begin n_fail++; $display("FAIL one_pc: got %0d want 9", pc); end
        ack_to_idle();
        n_checks++; if (fetch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL one_idle: valid=%b busy=%b want 0 0", fetch_valid, busy); end
        $display("txn one_word: hi=%h lo=%h pc=%0d", ir_hi, ir_lo, pc);
    endtask

    task automatic test_two_word();
        int e;
        apply_reset();
        mem[8] = 16'h0018;
        mem[9] = 16'h00AB;
        issue_fetch(1'b0, 6'd0);
        wait_valid(e);
        n_checks++; if (e != 3) begin n_fail++; $display("FAIL two_latency: got %0d want 3", e); end
        n_checks++; if (ir_hi !== 16'h0018 || ir_lo !== 16'h00AB) begin n_fail++; $display("FAIL two_ir: got %h/%h want 0018/00ab", ir_hi, ir_lo); end
        n_checks++; if (pc !== 6'd10) begin n_fail++; $display("FAIL two_pc: got %0d want 10", pc); end
        $display("txn two_word: hi=%h lo=%h pc=%0d", ir_hi, ir_lo, pc);
        ack_to_idle();
    endtask

    task automatic test_back_to_back();
        int e;
        logic [15:0] w2;
        apply_reset();
        mem[8] = 16'h5123;
        w2 = rand_word(1'b0);
        mem[9] = w2;
        issue_fetch(1'b0, 6'd0);
        wait_valid(e);
        // DONE must hold its outputs while the CPU has not acked.
        repeat (2) @(negedge clk);
        n_checks++; if (fetch_valid !== 1'b1 || ir_hi !== 16'h5123) begin n_fail++; $display("FAIL b2b_hold: valid=%b hi=%h want 1 5123", fetch_valid, ir_hi); end
        fetch_ack = 1'b1;
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_ack = 1'b0;
        fetch_req = 1'b0;
        n_checks++; if (busy !== 1'b1 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_idle: busy=%b valid=%b want 1 0", busy, fetch_valid); end
        wait_valid(e);
        n_checks++; if (e != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want 2", e); end
        n_checks++; if (ir_hi !== w2 || ir_lo !== 16'h0 || pc !== 6'd10) begin n_fail++; $display("FAIL b2b_second: got %h/%h pc=%0d want %h/0000 pc=10", ir_hi, ir_lo, pc, w2); end
        $display("txn back_to_back: hi=%h lo=%h pc=%0d", ir_hi, ir_lo, pc);
        model_pc = 10;
    endtask

    task automatic test_jump();
        int e;
        logic [15:0] w;
        // Entered in DONE.
        pc_load = 1'b1;
        pc_in   = 6'd20;
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        n_checks++; if (pc !== 6'd20 || mem_addr !== 6'd20) begin n_fail++; $display("FAIL jump_load: pc=%0d addr=%0d want 20 20", pc, mem_addr); end
        n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL jump_done_hold: valid=%b want 1", fetch_valid); end
        ack_to_idle();
        w = rand_word(1'b0);
        mem[20] = w;
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Now in FETCH1: a load here must be ignored.
        fetch_req = 1'b0;
        pc_load   = 1'b1;
        pc_in     = 6'd40;
        @(posedge clk);
        @(negedge clk);
        pc_load = 1'b0;
        wait_valid(e);
        n_checks++; if (ir_hi !== w || pc !== 6'd21) begin n_fail++; $display("FAIL jump_fetch: hi=%h pc=%0d want %h 21", ir_hi, pc, w); end
        $display("txn jump: hi=%h lo=%h pc=%0d", ir_hi, ir_lo, pc);
        ack_to_idle();
        model_pc = 21;
    endtask

    task automatic test_wrap();
        int e;
        mem[63] = 16'h1028;
        mem[0]  = 16'h0007;
        issue_fetch(1'b1, 6'd63);
        wait_valid(e);
        n_checks++; if (e != 3) begin n_fail++; $display("FAIL wrap_latency: got %0d want 3", e); end
        n_checks++; if (ir_hi !== 16'h1028 || ir_lo !== 16'h0007) begin n_fail++; $display("FAIL wrap_ir: got %h/%h want 1028/0007", ir_hi, ir_lo); end
        n_checks++; if (pc !== 6'd1) begin n_fail++; $display("FAIL wrap_pc: got %0d want 1", pc); end
        n_checks++; if (fetch_err !== ERR_EN) begin n_fail++; $display("FAIL wrap_err: got %b want %b", fetch_err, ERR_EN); end
        $display("txn wrap: hi=%h lo=%h pc=%0d err=%b", ir_hi, ir_lo, pc, fetch_err);
        ack_to_idle();
        // Second pass: abort with reset while in FETCH2.
        fetch_req = 1'b1;
        pc_load   = 1'b1;
        pc_in     = 6'd63;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || pc !== 6'd0) begin n_fail++; $display("FAIL wrap_in_fetch2: busy=%b pc=%0d want 1 0", busy, pc); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 6'd8 || fetch_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_reset: pc=%0d valid=%b busy=%b want 8 0 0", pc, fetch_valid, busy); end
        n_checks++; if (ir_hi !== 16'h0 || ir_lo !== 16'h0 || fetch_err !== 1'b0) begin n_fail++; $display("FAIL abort_clear: ir=%h/%h err=%b want 0/0 0", ir_hi, ir_lo, fetch_err); end
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = 8;
        exp_err  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (fetch_valid !== 1'b0 || busy !== 1'b0 || pc !== 6'd8) begin n_fail++; $display("FAIL abort_stays_idle: valid=%b busy=%b pc=%0d want 0 0 8", fetch_valid, busy, pc); end
    endtask

    task automatic test_random();
        int e, np, lat, start;
        bit wrap, load;
        logic [5:0] target;
        logic [15:0] hi, lo;
        for (int t = 0; t < 24; t++) begin
            load   = 1'($urandom_range(0, 1));
            target = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(61, 63)) : 6'($urandom);
            start  = load ? int'(target) : model_pc;
            mem[start]            = rand_word(1'($urandom_range(0, 1)));
            mem[(start + 1) % 64] = rand_word(1'($urandom_range(0, 1)));
            model_fetch(start, hi, lo, np, wrap, lat);
            issue_fetch(load, target);
            wait_valid(e);
            exp_err  = exp_err | wrap;
            model_pc = np;
            n_checks++; if (e != lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", t, e, lat); end
            n_checks++; if (ir_hi !== hi || ir_lo !== lo) begin n_fail++; $display("FAIL rand%0d_ir: got %h/%h want %h/%h", t, ir_hi, ir_lo, hi, lo); end
            n_checks++; if (pc !== 6'(np) || mem_addr !== 6'(np)) begin n_fail++; $display("FAIL rand%0d_pc: pc=%0d addr=%0d want %0d", t, pc, mem_addr, np); end
            n_checks++; if (fetch_err !== (ERR_EN & exp_err)) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", t, fetch_err, ERR_EN & exp_err); end
            $display("txn rand %0d: start=%0d load=%b hi=%h lo=%h pc=%0d err=%b", t, start, load, ir_hi, ir_lo, pc, fetch_err);
            ack_to_idle();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        test_reset();
        test_one_word();
        test_two_word();
        test_back_to_back();
        test_jump();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
